// File: rtl/max_reduce_pkg.sv
// Shared types for the streaming max/min reduction unit: FSM states and
// the encodings of the SIGNED / MODE_MIN configuration parameters.
package max_reduce_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam bit CMP_UNSIGNED = 1'b0;
  localparam bit CMP_SIGNED   = 1'b1;

  localparam bit RED_MAX = 1'b0;
  localparam bit RED_MIN = 1'b1;

endpackage

// File: rtl/cmp_int_nbit.sv
// Combinational a > b on WIDTH-bit integers. Signed operands have their MSB
// flipped, which maps two's complement order onto unsigned order.
module cmp_int_nbit
  import max_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = CMP_UNSIGNED
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o
);

  localparam logic [WIDTH-1:0] FLIP =
    (SIGNED == CMP_SIGNED) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  assign a_key = a_i ^ FLIP;
  assign b_key = b_i ^ FLIP;
  assign gt_o  = a_key > b_key;

endmodule

// File: rtl/max_reduce_stream.sv
// Framed streaming max/min reduction: one element per cycle in, one
// {extreme value, first index, overflow} result per frame out.
module max_reduce_stream
  import max_reduce_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 8,
  parameter bit SIGNED   = CMP_UNSIGNED,
  parameter bit MODE_MIN = RED_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf
);

  // One extra counter bit so a frame of exactly 2^IDX_W elements stays exact.
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_val_q, acc_val_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             beat;
  logic             better;
  logic             cnt_full;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;

  // Min mode asks "is the accumulator greater than the new element".
  assign cmp_a = (MODE_MIN == RED_MIN) ? acc_val_q : in_data;
  assign cmp_b = (MODE_MIN == RED_MIN) ? in_data   : acc_val_q;

  cmp_int_nbit #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp (
    .a_i (cmp_a),
    .b_i (cmp_b),
    .gt_o(better)
  );

  assign beat     = in_valid && in_ready;
  assign cnt_full = cnt_q[IDX_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output is given a default first, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (beat) state_d = in_last ? DONE : ACCUM;
      ACCUM:   if (beat && in_last) state_d = DONE;
      DONE:    if (out_ready) state_d = !beat ? EMPTY : (in_last ? DONE : ACCUM);
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != DONE) || out_ready;
    out_valid = (state_q == DONE);
  end

  // A beat outside ACCUM always opens a new frame (EMPTY, or DONE being drained).
  always_comb begin
    acc_val_d = acc_val_q;
    acc_idx_d = acc_idx_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (beat) begin
      if (state_q == ACCUM) begin
        if (better) begin
          acc_val_d = in_data;
          acc_idx_d = cnt_full ? '1 : cnt_q[IDX_W-1:0];
        end
        cnt_d = cnt_full ? cnt_q : cnt_q + CNT_ONE;
        ovf_d = ovf_q | cnt_full;
      end else begin
        acc_val_d = in_data;
        acc_idx_d = '0;
        cnt_d     = CNT_ONE;
        ovf_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_val_q <= '0;
      acc_idx_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      acc_val_q <= acc_val_d;
      acc_idx_q <= acc_idx_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // The accumulator is frozen while DONE, so it doubles as the result register.
  assign out_val = acc_val_q;
  assign out_idx = acc_idx_q;
  assign out_ovf = ovf_q;

endmodule
